// File: rtl/rb_pkg.sv
// Shared widths, FSM state encoding and issue payload for the operand collector.
package rb_pkg;

   localparam int unsigned LANES  = 8;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned AW     = 6;
   localparam int unsigned WW     = 4;
   localparam int unsigned TAG_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      OUT  = 2'd2
   } state_e;

   typedef logic [DATA_W-1:0] lane_data_t;

   typedef struct packed {
      logic [WW-1:0]    warp;
      logic [AW-1:0]    rs0;
      logic [AW-1:0]    rs1;
      logic             need0;
      logic             need1;
      logic [LANES-1:0] mask;
      logic [TAG_W-1:0] tag;
   } issue_req_t;

endpackage

// File: rtl/operand_collector_if.sv
// Issue, writeback, register_block read-port and execute-side signals of the collector.
interface operand_collector_if;
   import rb_pkg::*;

   logic                    iss_valid;
   logic                    iss_ready;
   logic [WW-1:0]           iss_warp;
   logic [AW-1:0]           iss_rs0;
   logic [AW-1:0]           iss_rs1;
   logic                    iss_need0;
   logic                    iss_need1;
   logic [LANES-1:0]        iss_mask;
   logic [TAG_W-1:0]        iss_tag;

   logic [LANES-1:0]        wb_en;
   logic [WW-1:0]           wb_warp;
   logic [AW-1:0]           wb_addr;
   logic [LANES*DATA_W-1:0] wb_data;
   logic                    wb_stall;

   logic [LANES-1:0]        read_en_0;
   logic [LANES-1:0]        read_en_1;
   logic [AW-1:0]           raddr_0;
   logic [AW-1:0]           raddr_1;
   logic [WW-1:0]           warp_selector;
   logic [LANES*DATA_W-1:0] rdata_0;
   logic [LANES*DATA_W-1:0] rdata_1;

   logic                    op_valid;
   logic                    op_ready;
   logic [TAG_W-1:0]        op_tag;
   logic [LANES-1:0]        op_mask;
   logic [LANES*DATA_W-1:0] op0;
   logic [LANES*DATA_W-1:0] op1;

   modport master (
      output iss_valid, iss_warp, iss_rs0, iss_rs1, iss_need0, iss_need1, iss_mask, iss_tag,
      output wb_en, wb_warp, wb_addr, wb_data, rdata_0, rdata_1, op_ready,
      input  iss_ready, wb_stall, read_en_0, read_en_1, raddr_0, raddr_1, warp_selector,
      input  op_valid, op_tag, op_mask, op0, op1
   );

   modport slave (
      input  iss_valid, iss_warp, iss_rs0, iss_rs1, iss_need0, iss_need1, iss_mask, iss_tag,
      input  wb_en, wb_warp, wb_addr, wb_data, rdata_0, rdata_1, op_ready,
      output iss_ready, wb_stall, read_en_0, read_en_1, raddr_0, raddr_1, warp_selector,
      output op_valid, op_tag, op_mask, op0, op1
   );

endinterface

// File: rtl/operand_collector_lane_capture.sv
// One lane of one operand port: zero when inactive, else writeback bypass or register read.
module oc_lane_capture
   import rb_pkg::*;
(
   input  logic       lane_en_i,
   input  logic       fwd_i,
   input  lane_data_t rdata_i,
   input  lane_data_t wb_data_i,
   output lane_data_t data_c_o
);

   always_comb begin
      data_c_o = '0;
      if (lane_en_i) begin
         data_c_o = fwd_i ? wb_data_i : rdata_i;
      end
   end

endmodule

// File: rtl/operand_collector.sv
// Collects two lane-packed source operands from register_block for one issued instruction
// and hands them to execute; owns the warp selector, giving writeback priority.
module operand_collector
   import rb_pkg::*;
(
   input logic                clk,
   input logic                rst,
   operand_collector_if.slave bus
);

   localparam int unsigned VW = LANES * DATA_W;

   state_e           state_q, state_d;
   issue_req_t       req_q, req_d;
   logic             op_valid_q, op_valid_d;
   logic [TAG_W-1:0] op_tag_q, op_tag_d;
   logic [LANES-1:0] op_mask_q, op_mask_d;
   logic [VW-1:0]    op0_q, op0_d;
   logic [VW-1:0]    op1_q, op1_d;

   logic             iss_ready_c;
   logic [LANES-1:0] read_en_0_c, read_en_1_c;
   logic [AW-1:0]    raddr_0_c, raddr_1_c;
   logic [WW-1:0]    warp_sel_c;
   logic [VW-1:0]    cap0_c, cap1_c;

   logic wb_any, conflict, hit0, hit1;

   // A write to another warp owns the selector this cycle and blocks the read.
   assign wb_any   = |bus.wb_en;
   assign conflict = wb_any && (bus.wb_warp != req_q.warp);
   assign hit0     = wb_any && !conflict && req_q.need0 && (bus.wb_addr == req_q.rs0);
   assign hit1     = wb_any && !conflict && req_q.need1 && (bus.wb_addr == req_q.rs1);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      oc_lane_capture u_cap0 (
         .lane_en_i (req_q.mask[i] & req_q.need0),
         .fwd_i     (hit0 & bus.wb_en[i]),
         .rdata_i   (bus.rdata_0[i*DATA_W +: DATA_W]),
         .wb_data_i (bus.wb_data[i*DATA_W +: DATA_W]),
         .data_c_o  (cap0_c[i*DATA_W +: DATA_W])
      );
      oc_lane_capture u_cap1 (
         .lane_en_i (req_q.mask[i] & req_q.need1),
         .fwd_i     (hit1 & bus.wb_en[i]),
         .rdata_i   (bus.rdata_1[i*DATA_W +: DATA_W]),
         .wb_data_i (bus.wb_data[i*DATA_W +: DATA_W]),
         .data_c_o  (cap1_c[i*DATA_W +: DATA_W])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         req_q      <= '0;
         op_valid_q <= 1'b0;
         op_tag_q   <= '0;
         op_mask_q  <= '0;
         op0_q      <= '0;
         op1_q      <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         op_valid_q <= op_valid_d;
         op_tag_q   <= op_tag_d;
         op_mask_q  <= op_mask_d;
         op0_q      <= op0_d;
         op1_q      <= op1_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      op_valid_d  = op_valid_q;
      op_tag_d    = op_tag_q;
      op_mask_d   = op_mask_q;
      op0_d       = op0_q;
      op1_d       = op1_q;
      iss_ready_c = 1'b0;
      read_en_0_c = '0;
      read_en_1_c = '0;
      raddr_0_c   = '0;
      raddr_1_c   = '0;
      warp_sel_c  = wb_any ? bus.wb_warp : '0;

      unique case (state_q)
         IDLE: begin
            iss_ready_c = 1'b1;
         end
         READ: begin
            raddr_0_c = req_q.rs0;
            raddr_1_c = req_q.rs1;
            if (!wb_any) warp_sel_c = req_q.warp;
            if (!conflict) begin
               read_en_0_c = req_q.need0 ? req_q.mask : '0;
               read_en_1_c = req_q.need1 ? req_q.mask : '0;
               op0_d       = cap0_c;
               op1_d       = cap1_c;
               op_tag_d    = req_q.tag;
               op_mask_d   = req_q.mask;
               op_valid_d  = 1'b1;
               state_d     = OUT;
            end
         end
         OUT: begin
            if (!wb_any) warp_sel_c = req_q.warp;
            if (bus.op_ready) begin
               iss_ready_c = 1'b1;
               op_valid_d  = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Acceptance is shared by IDLE and the back-to-back path out of OUT.
      if (iss_ready_c && bus.iss_valid) begin
         req_d = '{warp:  bus.iss_warp,  rs0:   bus.iss_rs0,   rs1:  bus.iss_rs1,
                   need0: bus.iss_need0, need1: bus.iss_need1,
                   mask:  bus.iss_mask,  tag:   bus.iss_tag};
         state_d = READ;
      end
   end

   assign bus.iss_ready     = iss_ready_c;
   assign bus.wb_stall      = 1'b0;
   assign bus.read_en_0     = read_en_0_c;
   assign bus.read_en_1     = read_en_1_c;
   assign bus.raddr_0       = raddr_0_c;
   assign bus.raddr_1       = raddr_1_c;
   assign bus.warp_selector = warp_sel_c;
   assign bus.op_valid      = op_valid_q;
   assign bus.op_tag        = op_tag_q;
   assign bus.op_mask       = op_mask_q;
   assign bus.op0           = op0_q;
   assign bus.op1           = op1_q;

endmodule

// File: tb/tb_operand_collector.sv
// Bench for operand_collector with a register_block model and an operand scoreboard.
module tb_operand_collector;
   import rb_pkg::*;

   localparam int unsigned VW = LANES * DATA_W;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [LANES-1:0] mask;
      logic [VW-1:0]    op0;
      logic [VW-1:0]    op1;
   } exp_t;

   typedef struct {
      issue_req_t       req;
      logic [LANES-1:0] e_re0;
      logic [LANES-1:0] e_re1;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   initial forever #5 clk = ~clk;

   operand_collector_if bus();

   operand_collector dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   lane_data_t rb_mem  [8192];
   lane_data_t ref_mem [8192];
   exp_t       sb [$];

   function automatic int idx(input logic [WW-1:0] w, input logic [AW-1:0] a, input int l);
      return int'({w, a, 3'(l)});
   endfunction

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Combinational register_block read ports
   logic [VW-1:0] rd0, rd1;
   always_comb begin
      rd0 = '0;
      rd1 = '0;
      for (int i = 0; i < LANES; i++) begin
         rd0[i*DATA_W +: DATA_W] = rb_mem[idx(bus.warp_selector, bus.raddr_0, i)];
         rd1[i*DATA_W +: DATA_W] = rb_mem[idx(bus.warp_selector, bus.raddr_1, i)];
      end
   end
   assign bus.rdata_0 = rd0;
   assign bus.rdata_1 = rd1;

   function automatic logic [VW-1:0] exp_port(input logic [WW-1:0] w, input logic [AW-1:0] a,
                                              input logic need, input logic [LANES-1:0] mask);
      logic [VW-1:0] r;
      r = '0;
      for (int l = 0; l < LANES; l++)
         if (need && mask[l]) r[l*DATA_W +: DATA_W] = ref_mem[idx(w, a, l)];
      return r;
   endfunction

   task automatic push_exp(input issue_req_t r);
      exp_t e;
      e.tag  = r.tag;
      e.mask = r.mask;
      e.op0  = exp_port(r.warp, r.rs0, r.need0, r.mask);
      e.op1  = exp_port(r.warp, r.rs1, r.need1, r.mask);
      sb.push_back(e);
   endtask

   // Advance one clock; the register file commits the write sampled at this edge.
   task automatic step();
      @(posedge clk);
      if (!rst)
         for (int l = 0; l < LANES; l++)
            if (bus.wb_en[l]) rb_mem[idx(bus.wb_warp, bus.wb_addr, l)] = bus.wb_data[l*DATA_W +: DATA_W];
      #1;
   endtask

   task automatic drive_iss(input issue_req_t r);
      bus.iss_valid = 1'b1;
      bus.iss_warp  = r.warp;
      bus.iss_rs0   = r.rs0;
      bus.iss_rs1   = r.rs1;
      bus.iss_need0 = r.need0;
      bus.iss_need1 = r.need1;
      bus.iss_mask  = r.mask;
      bus.iss_tag   = r.tag;
   endtask

   task automatic wb_set(input logic [WW-1:0] w, input logic [AW-1:0] a,
                         input logic [LANES-1:0] en, input logic [VW-1:0] d);
      bus.wb_en   = en;
      bus.wb_warp = w;
      bus.wb_addr = a;
      bus.wb_data = d;
      for (int l = 0; l < LANES; l++)
         if (en[l]) ref_mem[idx(w, a, l)] = d[l*DATA_W +: DATA_W];
   endtask

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int k = 0; k < VW / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // Output monitor: stability under backpressure and scoreboard compare on transfer
   logic             prev_hold = 1'b0;
   logic [VW-1:0]    prev_op0, prev_op1;
   logic [TAG_W-1:0] prev_tag;
   logic [LANES-1:0] prev_mask;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_op0", bus.op0, prev_op0);
            chk("hold_op1", bus.op1, prev_op1);
            chk("hold_meta", VW'({bus.op_valid, bus.op_tag, bus.op_mask}), VW'({1'b1, prev_tag, prev_mask}));
         end
         if (bus.op_valid && bus.op_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected tag=%0h with empty scoreboard", bus.op_tag);
            end else begin
               e = sb.pop_front();
               chk("sb_op0", bus.op0, e.op0);
               chk("sb_op1", bus.op1, e.op1);
               chk("sb_meta", VW'({bus.op_tag, bus.op_mask}), VW'({e.tag, e.mask}));
            end
         end
         prev_hold = bus.op_valid && !bus.op_ready;
         prev_op0  = bus.op0;
         prev_op1  = bus.op1;
         prev_tag  = bus.op_tag;
         prev_mask = bus.op_mask;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      vec_t          vt [6];
      issue_req_t    r;
      logic [VW-1:0] k, wd;
      int            n;

      vt[0] = '{req: '{warp: 4'd3,  rs0: 6'h2A, rs1: 6'h00, need0: 1'b1, need1: 1'b0, mask: 8'hFF, tag: 4'h1}, e_re0: 8'hFF, e_re1: 8'h00};
      vt[1] = '{req: '{warp: 4'd1,  rs0: 6'h05, rs1: 6'h05, need0: 1'b1, need1: 1'b1, mask: 8'h0F, tag: 4'h2}, e_re0: 8'h0F, e_re1: 8'h0F};
      vt[2] = '{req: '{warp: 4'd4,  rs0: 6'h10, rs1: 6'h20, need0: 1'b0, need1: 1'b1, mask: 8'hA5, tag: 4'h3}, e_re0: 8'h00, e_re1: 8'hA5};
      vt[3] = '{req: '{warp: 4'd7,  rs0: 6'h3F, rs1: 6'h01, need0: 1'b1, need1: 1'b1, mask: 8'h00, tag: 4'h4}, e_re0: 8'h00, e_re1: 8'h00};
      vt[4] = '{req: '{warp: 4'd15, rs0: 6'h00, rs1: 6'h3F, need0: 1'b1, need1: 1'b1, mask: 8'hFF, tag: 4'h5}, e_re0: 8'hFF, e_re1: 8'hFF};
      vt[5] = '{req: '{warp: 4'd0,  rs0: 6'h00, rs1: 6'h00, need0: 1'b0, need1: 1'b0, mask: 8'hFF, tag: 4'h6}, e_re0: 8'h00, e_re1: 8'h00};

      for (int i = 0; i < 8192; i++) begin
         rb_mem[i]  = {16'hC0DE, 3'b000, 13'(i), 32'(i) * 32'h9E3779B1};
         ref_mem[i] = rb_mem[i];
      end
      bus.iss_valid = 1'b0; bus.iss_warp = '0; bus.iss_rs0 = '0; bus.iss_rs1 = '0;
      bus.iss_need0 = 1'b0; bus.iss_need1 = 1'b0; bus.iss_mask = '0; bus.iss_tag = '0;
      bus.wb_en = '0; bus.wb_warp = '0; bus.wb_addr = '0; bus.wb_data = '0;
      bus.op_ready = 1'b1;

      #1 rst = 1'b1;
      #11;
      chk("rst_ctrl", VW'({bus.op_valid, bus.read_en_0, bus.read_en_1, bus.raddr_0, bus.raddr_1,
                          bus.warp_selector, bus.wb_stall, bus.op_tag, bus.op_mask}), '0);
      chk("rst_op0", bus.op0, '0);
      chk("rst_op1", bus.op1, '0);
      chk("rst_iss_ready", VW'(bus.iss_ready), VW'(1'b1));
      @(posedge clk); #1 rst = 1'b0;

      // Preload warp 3 reg 0x2A with 0x11..0x88 through the write port
      for (int l = 0; l < LANES; l++) k[l*DATA_W +: DATA_W] = 64'(8'h11 * (l + 1));
      wb_set(4'd3, 6'h2A, 8'hFF, k);
      step();
      bus.wb_en = '0;

      for (int i = 0; i < 6; i++) begin
         push_exp(vt[i].req);
         drive_iss(vt[i].req);
         step();
         bus.iss_valid = 1'b0;
         #1;
         chk($sformatf("tbl%0d_read", i),
             VW'({bus.op_valid, bus.read_en_0, bus.read_en_1, bus.raddr_0, bus.raddr_1, bus.warp_selector}),
             VW'({1'b0, vt[i].e_re0, vt[i].e_re1, vt[i].req.rs0, vt[i].req.rs1, vt[i].req.warp}));
         step();
         chk($sformatf("tbl%0d_lat", i), VW'(bus.op_valid), VW'(1'b1));
         if (i == 0) chk("tbl0_op0_const", bus.op0, k);
         step();
         chk($sformatf("tbl%0d_idle", i), VW'({bus.op_valid, bus.iss_ready}), VW'(2'b01));
      end

      // Conflicting writes to warp 7 stall a warp-2 read for three cycles
      r = '{warp: 4'd2, rs0: 6'h10, rs1: 6'h11, need0: 1'b1, need1: 1'b1, mask: 8'hFF, tag: 4'h7};
      push_exp(r);
      drive_iss(r);
      step();
      bus.iss_valid = 1'b0;
      n = 1;
      for (int c = 0; c < 3; c++) begin
         wb_set(4'd7, 6'h30, 8'hFF, rand_vec());
         #1;
         chk($sformatf("conflict%0d", c),
             VW'({bus.warp_selector, bus.read_en_0, bus.read_en_1, bus.wb_stall, bus.op_valid}),
             VW'({4'd7, 8'h00, 8'h00, 1'b0, 1'b0}));
         step();
         n++;
      end
      bus.wb_en = '0;
      #1;
      chk("conflict_release", VW'({bus.warp_selector, bus.read_en_0, bus.read_en_1}), VW'({4'd2, 8'hFF, 8'hFF}));
      step();
      n++;
      chk("conflict_lat", VW'({n[7:0], bus.op_valid}), VW'({8'd5, 1'b1}));
      step();

      // Same-warp write to rs1 lanes 0/1 is forwarded during READ
      r = '{warp: 4'd5, rs0: 6'h08, rs1: 6'h09, need0: 1'b1, need1: 1'b1, mask: 8'hFF, tag: 4'h8};
      wd = rand_vec();
      wd[0 +: DATA_W]      = 64'hDEAD;
      wd[DATA_W +: DATA_W] = 64'hBEEF;
      for (int l = 0; l < 2; l++) ref_mem[idx(4'd5, 6'h09, l)] = wd[l*DATA_W +: DATA_W];
      push_exp(r);
      drive_iss(r);
      step();
      bus.iss_valid = 1'b0;
      wb_set(4'd5, 6'h09, 8'h03, wd);
      #1;
      chk("bypass_read", VW'({bus.warp_selector, bus.read_en_0, bus.read_en_1}), VW'({4'd5, 8'hFF, 8'hFF}));
      step();
      bus.wb_en = '0;
      chk("bypass_lanes01", VW'(bus.op1[2*DATA_W-1:0]), VW'({64'hBEEF, 64'hDEAD}));
      step();

      // rs0 == rs1 with both needed: both ports see the forwarded lanes
      r = '{warp: 4'd6, rs0: 6'h0C, rs1: 6'h0C, need0: 1'b1, need1: 1'b1, mask: 8'hFF, tag: 4'hA};
      wd = rand_vec();
      for (int l = 0; l < LANES; l++)
         if (l == 0 || l == 7) ref_mem[idx(4'd6, 6'h0C, l)] = wd[l*DATA_W +: DATA_W];
      push_exp(r);
      drive_iss(r);
      step();
      bus.iss_valid = 1'b0;
      wb_set(4'd6, 6'h0C, 8'h81, wd);
      step();
      bus.wb_en = '0;
      chk("dualfwd_valid", VW'(bus.op_valid), VW'(1'b1));
      step();

      // Backpressure for four cycles, then back-to-back accept
      bus.op_ready = 1'b0;
      r = '{warp: 4'd3, rs0: 6'h2A, rs1: 6'h05, need0: 1'b1, need1: 1'b1, mask: 8'hFF, tag: 4'h9};
      push_exp(r);
      drive_iss(r);
      step();
      bus.iss_valid = 1'b0;
      step();
      chk("bp_valid", VW'(bus.op_valid), VW'(1'b1));
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("bp_hold%0d", c), VW'({bus.op_valid, bus.iss_ready}), VW'(2'b10));
      end
      bus.op_ready = 1'b1;
      r = '{warp: 4'd9, rs0: 6'h11, rs1: 6'h12, need0: 1'b1, need1: 1'b1, mask: 8'h3C, tag: 4'hB};
      push_exp(r);
      drive_iss(r);
      #1;
      chk("b2b_ready", VW'(bus.iss_ready), VW'(1'b1));
      step();
      bus.iss_valid = 1'b0;
      #1;
      chk("b2b_drop", VW'({bus.op_valid, bus.read_en_0}), VW'({1'b0, 8'h3C}));
      step();
      chk("b2b_lat", VW'({bus.op_valid, bus.op_tag}), VW'({1'b1, 4'hB}));
      step();

      // Reset during READ discards the in-flight instruction
      r = '{warp: 4'd8, rs0: 6'h21, rs1: 6'h22, need0: 1'b1, need1: 1'b0, mask: 8'hF0, tag: 4'hC};
      drive_iss(r);
      step();
      bus.iss_valid = 1'b0;
      #1;
      chk("rst_pre", VW'(bus.read_en_0), VW'(8'hF0));
      rst = 1'b1;
      #1;
      chk("rst_async", VW'({bus.op_valid, bus.read_en_0, bus.read_en_1, bus.raddr_0,
                           bus.raddr_1, bus.warp_selector, bus.op_tag, bus.op_mask}), '0);
      chk("rst_async_op0", bus.op0, '0);
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_release_ready", VW'(bus.iss_ready), VW'(1'b1));
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("rst_no_valid%0d", c), VW'(bus.op_valid), VW'(1'b0));
      end

      chk("sb_empty", VW'(sb.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
- Read-side master for register_block: accepts one issued instruction (warp, up to two source register addresses, lane mask) and drives the block's two read ports.
- Captures the 8 lanes x 2 operands and presents them to the execute stage with a valid/ready handshake.
- Owns the shared warp_selector: a concurrent writeback request is granted the selector and forwarded into operands on an address match.
- Sits between issue/scoreboard and the SIMD execute lanes.

Parameters:
LANES, 8, SIMD lanes per warp
DATA_W, 64, register width
AW, 6, register address width (64 registers)
WW, 4, warp id width (16 warps)
TAG_W, 4, instruction tag carried to execute

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
iss_valid  in  1  issue request valid
iss_ready  out  1  collector can accept issue
iss_warp  in  WW  warp of instruction
iss_rs0  in  AW  source 0 register
iss_rs1  in  AW  source 1 register
iss_need0  in  1  source 0 required
iss_need1  in  1  source 1 required
iss_mask  in  LANES  active lanes
iss_tag  in  TAG_W  instruction tag
wb_en  in  LANES  writeback lane enables (0 = no write)
wb_warp  in  WW  writeback warp
wb_addr  in  AW  writeback register
wb_data  in  LANES*DATA_W  writeback data, lane i at [i*DATA_W +: DATA_W]
wb_stall  out  1  writeback must hold this cycle
read_en_0  out  LANES  register_block port 0 lane enables
read_en_1  out  LANES  register_block port 1 lane enables
raddr_0  out  AW  port 0 address
raddr_1  out  AW  port 1 address
warp_selector  out  WW  register_block warp select
rdata_0  in  LANES*DATA_W  port 0 read data, lane-packed
rdata_1  in  LANES*DATA_W  port 1 read data, lane-packed
op_valid  out  1  operands valid
op_ready  in  1  execute accepts
op_tag  out  TAG_W  tag of held instruction
op_mask  out  LANES  lane mask of held instruction
op0  out  LANES*DATA_W  source 0 operands
op1  out  LANES*DATA_W  source 1 operands

Behaviour:
- FSM states IDLE, READ, OUT. Reset: state IDLE; op_valid, op_tag, op_mask, op0, op1, read_en_0/1, raddr_0/1, warp_selector, wb_stall all 0.
- iss_ready = (state==IDLE) | (state==OUT & op_ready). Accepting latches warp/rs0/rs1/need/mask/tag and moves to READ.
- register_block read is combinational; capture happens at the rising edge ending the READ cycle.
- READ: read_en_0 = need0 ? mask : 0; read_en_1 = need1 ? mask : 0; raddr_x = latched rs.
- Warp arbitration, write has priority:
  - warp_selector = wb_warp when wb_en!=0, else the latched read warp; 0 in IDLE with no write.
  - In READ with wb_en!=0 and wb_warp!=read warp: read enables forced to 0, no capture, stay READ (conflict stall).
  - Same warp: capture proceeds.
- wb_stall is always 0; the write is never blocked.
- Bypass: same warp, wb_addr==rs0, need0 -> op0 lane i = wb_data lane i where wb_en[i], else rdata_0 lane i. Same rule for rs1/op1. rs0==rs1 with both needed: both forwarded.
- Capture: lanes outside mask, or sources not needed, are written as 0. op_valid=1, state OUT.
- Latency: accept at cycle T -> op_valid at T+2 with no conflict; +1 per conflict cycle.
- OUT: outputs held stable while op_valid & !op_ready.
  - op_ready & iss_valid -> back-to-back accept, go to READ, op_valid drops.
  - op_ready & !iss_valid -> IDLE, op_valid 0.
- iss_mask==0: no lane reads; still passes through READ and OUT with zero operands.
- Reset asserted mid-operation: immediate return to reset values; the in-flight instruction is discarded.

Decomposition:
- Shared package rb_pkg: LANES, DATA_W, AW, WW, TAG_W constants; state enum (IDLE, READ, OUT); lane_data_t; issue_req_t struct {warp, rs0, rs1, need0, need1, mask, tag}.
- One natural sub-module: oc_lane_capture, per-lane mux of rdata vs wb_data vs 0, instantiated LANES times per port.

Test Plan:
- Write lanes 0-7 of warp 3 reg 0x2A with 0x11..0x88 via register_block; issue warp 3, rs0=0x2A, need0=1, mask=0xFF -> op_valid at T+2, op0 lanes = 0x11..0x88, op1 = 0, read_en_1 = 0.
- Issue mask=0x0F, rs0=rs1=0x05 -> lanes 4-7 of op0/op1 = 0; lanes 0-3 identical on both ports.
- During READ, wb_en=0xFF, wb_warp=7, read warp=2 -> warp_selector=7, read enables 0 for 3 cycles of writes, op_valid delayed to T+5, data correct for warp 2.
- During READ, same warp, wb_addr=rs1, wb_en=0x03, wb_data lanes 0/1=0xDEAD/0xBEEF -> op1 lanes 0/1 forwarded, lanes 2-7 from rdata_1.
- Hold op_ready=0 for 4 cycles, then op_ready=1 with iss_valid=1 -> operands stable throughout; second instruction accepted same cycle; its op_valid 2 cycles later.
- Assert rst during READ -> all outputs 0 asynchronously, state IDLE, iss_ready=1 after release; no op_valid for the dropped instruction.
